// File: rtl/voodoo_sha_schedule_if.sv
// Handshake/bus bundle for the SHA-256 message schedule generator.
//   load, block   : start request and 512-bit message block (word i = block[32*i+31:32*i])
//   w_ready       : downstream accepts w/k this cycle
//   w_valid, w, k, stage : current schedule word, round constant and round index
//   busy, done    : status; done is a one-cycle pulse after the last transfer
// Modports: slave = schedule generator side, master = requester/consumer side.
interface voodoo_sha_schedule_if;
    logic         load;
    logic [511:0] block;
    logic         w_ready;
    logic         w_valid;
    logic [31:0]  w;
    logic [31:0]  k;
    logic [6:0]   stage;
    logic         busy;
    logic         done;

    modport slave (
        input  load, block, w_ready,
        output w_valid, w, k, stage, busy, done
    );

    modport master (
        output load, block, w_ready,
        input  w_valid, w, k, stage, busy, done
    );
endinterface

// File: rtl/voodoo_sha_schedule.sv
// SHA-256 message schedule generator.
// Captures a 512-bit block into a 16-word sliding window and streams W[0..ROUNDS-1]
// with a valid/ready handshake. Each accepted word shifts the window and appends
// s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : voodoo_sha_schedule_if.slave (load/block/w_ready in, w_valid/w/k/stage/busy/done out)
// Parameter ROUNDS (16..64): schedule words emitted per block.
// Optional feature: define VOODOO_SCHED_KROM_EN to drive k from the 64-entry SHA-256
// constant ROM indexed by stage; otherwise k is constant 0 and no ROM exists.
module voodoo_sha_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    voodoo_sha_schedule_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [6:0] LAST_STAGE = 7'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [31:0] window_reg [16];
    logic [31:0] block_word [16];
    logic [31:0] w_reg;
    logic [6:0]  stage_reg;
    logic [31:0] new_word;
    logic        start;
    logic        transfer;
    logic        last;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_block_words
        assign block_word[gi] = bus.block[32*gi +: 32];
    end

    assign start    = (state_reg == IDLE) && bus.load;
    assign transfer = (state_reg == RUN) && bus.w_ready;
    assign last     = (stage_reg == LAST_STAGE);
    assign new_word = sig1(window_reg[14]) + window_reg[9] + sig0(window_reg[1]) + window_reg[0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.load) state_next = RUN;
            RUN:     if (transfer && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // w and stage are kept in their own registers rather than read from the window so
    // that they keep showing the last transferred word/index after the block ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            w_reg     <= '0;
            for (int i = 0; i < 16; i++) window_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                for (int i = 0; i < 16; i++) window_reg[i] <= block_word[i];
                stage_reg <= '0;
                w_reg     <= block_word[0];
            end else if (transfer) begin
                for (int i = 0; i < 15; i++) window_reg[i] <= window_reg[i+1];
                window_reg[15] <= new_word;
                if (!last) begin
                    stage_reg <= stage_reg + 7'd1;
                    w_reg     <= window_reg[1];
                end
            end
        end
    end

`ifdef VOODOO_SCHED_KROM_EN
    localparam logic [31:0] KROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] k_reg;
    logic [5:0]  k_next_idx;

    // Registered ROM read addressed by the stage about to be presented, so k lines up
    // with stage on the same cycle.
    assign k_next_idx = 6'(stage_reg + 7'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_reg <= '0;
        end else if (start) begin
            k_reg <= KROM[0];
        end else if (transfer && !last) begin
            k_reg <= KROM[k_next_idx];
        end
    end

    assign bus.k = k_reg;
`else
    assign bus.k = '0;
`endif

    assign bus.w       = w_reg;
    assign bus.stage   = stage_reg;
    assign bus.w_valid = (state_reg == RUN);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);

endmodule
